// File: rtl/acc_to_q35_requant.sv
// acc_to_q35_requant: turns signed fixed-point MAC accumulator results into
// 8-bit Q3.5 samples for the GELU stage. It rounds half-up, then saturates.
// It is a 2-stage pipeline with valid/ready on both sides and a sticky
// saturation counter.
// Ports:
//   clk, reset (sync, active-high).
//   in_valid/in_ready/in_data: accumulator stream.
//   out_valid/out_ready/out_data/out_sat: Q3.5 stream.
//   clr_count/sat_count: debug counter of delivered saturated samples.
module acc_to_q35_requant #(
   parameter int ACC_W   = 20,
   parameter int FRAC_IN = 10,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ACC_W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             out_sat,
   input  logic             clr_count,
   output logic [CNT_W-1:0] sat_count
);

   localparam int SHIFT = FRAC_IN - 5;
   localparam int SUM_W = ACC_W + 1;
   localparam int R_W   = SUM_W - SHIFT;

   localparam logic [SUM_W-1:0]        HALF_LSB = {{(SUM_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
   localparam logic signed [R_W-1:0]   SAT_MAX  = R_W'(127);
   localparam logic signed [R_W-1:0]   SAT_MIN  = R_W'(-128);

   logic                    s1_valid;
   logic signed [R_W-1:0]   s1_r;
   logic                    s2_free;
   logic                    in_fire;
   logic signed [SUM_W-1:0] sum;
   logic signed [R_W-1:0]   rnd;
   logic                    sat_hi;
   logic                    sat_lo;

   assign s2_free  = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_free;
   assign in_fire  = in_valid && in_ready;

   // The sum is one bit wider than the input, so adding the half-LSB cannot
   // overflow. Keeping the upper bits is the same as an arithmetic shift
   // right by SHIFT. That gives floor((x + half) / 2^SHIFT), which is
   // round-half-up.
   assign sum = $signed({in_data[ACC_W-1], in_data}) + $signed(HALF_LSB);
   assign rnd = sum[SUM_W-1:SHIFT];

   assign sat_hi = s1_r > SAT_MAX;
   assign sat_lo = s1_r < SAT_MIN;

   // Stage 1: rounded value.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_r     <= '0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_r     <= rnd;
      end else if (s2_free) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: saturated Q3.5 output register. It holds while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (s2_free) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            if (sat_hi) begin
               out_data <= 8'h7f;
               out_sat  <= 1'b1;
            end else if (sat_lo) begin
               out_data <= 8'h80;
               out_sat  <= 1'b1;
            end else begin
               out_data <= s1_r[7:0];
               out_sat  <= 1'b0;
            end
         end
      end
   end

   // Counts saturated samples as they are delivered downstream, not as they
   // are produced. The count sticks at all-ones. A clear wins over a
   // same-cycle increment.
   always_ff @(posedge clk) begin
      if (reset || clr_count) begin
         sat_count <= '0;
      end else if (out_valid && out_ready && out_sat && (sat_count != {CNT_W{1'b1}})) begin
         sat_count <= sat_count + CNT_W'(1);
      end
   end

endmodule
